// File: rtl/vote_pkg.sv
// Shared types, frame layout constants and helpers for the vote result reporter.
package vote_pkg;

    localparam int unsigned NUM_CAND    = 4;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned FRAME_LEN   = 7;
    localparam int unsigned PAYLOAD_LEN = FRAME_LEN - 1;
    localparam int unsigned PAYLOAD_W   = PAYLOAD_LEN * BYTE_W;

    // Byte positions within the result frame
    localparam int unsigned BYTE_HDR    = 0;
    localparam int unsigned BYTE_VC1    = 1;
    localparam int unsigned BYTE_VC2    = 2;
    localparam int unsigned BYTE_VC3    = 3;
    localparam int unsigned BYTE_VC4    = 4;
    localparam int unsigned BYTE_STATUS = 5;
    localparam int unsigned BYTE_CSUM   = 6;

    localparam logic [7:0] DEF_FRAME_HEADER = 8'hA5;
    localparam logic [7:0] DEF_TIE_PATTERN  = 8'h0F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_COMPARE,
        ST_SEND
    } state_t;

    // XOR of all payload bytes; becomes the trailing checksum byte
    function automatic logic [7:0] payload_xor(input logic [PAYLOAD_W-1:0] p);
        logic [7:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < PAYLOAD_LEN; i++) begin
            acc = acc ^ p[i*BYTE_W +: BYTE_W];
        end
        return acc;
    endfunction

    // Status byte: tie flag in bit 7, winner (zeroed on tie) in bits 2:0
    function automatic logic [7:0] status_byte(input logic t, input logic [2:0] w);
        return {t, 4'b0000, (t ? 3'd0 : w)};
    endfunction

endpackage

// File: rtl/vote_result_reporter_frame_tx.sv
// Valid/ready byte sequencer: sends a 6-byte payload followed by its XOR checksum.
module vote_frame_tx
    import vote_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [PAYLOAD_W-1:0] i_payload,
    input  logic                 i_ready,
    output logic [7:0]           o_data,
    output logic                 o_valid,
    output logic                 o_done_c
);

    logic [PAYLOAD_W-1:0] r_payload;
    logic [7:0]           r_csum;
    logic [2:0]           r_idx;
    logic [7:0]           r_data;
    logic                 r_valid;

    logic                 w_xfer;
    logic                 w_last;
    logic [2:0]           w_next_idx;
    logic [7:0]           w_next_byte;

    assign w_xfer     = r_valid & i_ready;
    assign w_last     = (r_idx == 3'(BYTE_CSUM));
    assign w_next_idx = r_idx + 3'd1;

    // Byte that follows the one currently on the bus
    always_comb begin
        w_next_byte = r_csum;
        if (w_next_idx != 3'(BYTE_CSUM)) begin
            w_next_byte = 8'(r_payload >> (32'(w_next_idx) * BYTE_W));
        end
    end

    // Load on start, advance one byte per accepted transfer, drop valid after the checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_payload <= '0;
            r_csum    <= '0;
            r_idx     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
        end else if (i_start) begin
            r_payload <= i_payload;
            r_csum    <= payload_xor(i_payload);
            r_idx     <= 3'(BYTE_HDR);
            r_data    <= i_payload[BYTE_HDR*BYTE_W +: BYTE_W];
            r_valid   <= 1'b1;
        end else if (w_xfer) begin
            if (w_last) begin
                r_idx   <= '0;
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_idx  <= w_next_idx;
                r_data <= w_next_byte;
            end
        end
    end

    assign o_data   = r_data;
    assign o_valid  = r_valid;
    assign o_done_c = w_xfer & w_last;

endmodule

// File: rtl/vote_result_reporter.sv
// Result read-out: snapshots four vote counters, finds the winner or a tie,
// streams a result frame and shows the winning count on the LEDs.
module vote_result_reporter
    import vote_pkg::*;
#(
    parameter logic [7:0] FRAME_HEADER = DEF_FRAME_HEADER,
    parameter logic [7:0] TIE_PATTERN  = DEF_TIE_PATTERN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       report_req,
    input  logic [7:0] vc1,
    input  logic [7:0] vc2,
    input  logic [7:0] vc3,
    input  logic [7:0] vc4,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic [2:0] winner,
    output logic       tie,
    output logic [7:0] led
);

    state_t               r_state;
    logic [7:0]           r_vc [NUM_CAND];
    logic [2:0]           r_idx;
    logic [7:0]           r_max;
    logic [2:0]           r_run_win;
    logic                 r_run_tie;
    logic                 r_busy;
    logic [2:0]           r_winner;
    logic                 r_tie;
    logic [7:0]           r_led;

    logic [7:0]           w_cand;
    logic                 w_start;
    logic                 w_done;
    logic [PAYLOAD_W-1:0] w_payload;

    assign w_cand  = r_vc[r_idx[1:0]];
    assign w_start = (r_state == ST_COMPARE) && mode && (r_idx == 3'(NUM_CAND));

    // Frame payload assembled from the snapshots and the final running result
    always_comb begin
        w_payload = '0;
        w_payload[BYTE_HDR*BYTE_W    +: BYTE_W] = FRAME_HEADER;
        w_payload[BYTE_VC1*BYTE_W    +: BYTE_W] = r_vc[0];
        w_payload[BYTE_VC2*BYTE_W    +: BYTE_W] = r_vc[1];
        w_payload[BYTE_VC3*BYTE_W    +: BYTE_W] = r_vc[2];
        w_payload[BYTE_VC4*BYTE_W    +: BYTE_W] = r_vc[3];
        w_payload[BYTE_STATUS*BYTE_W +: BYTE_W] = status_byte(r_run_tie, r_run_win);
    end

    vote_frame_tx u_frame_tx (
        .clk       (clk),
        .rst_n     (reset),
        .i_start   (w_start),
        .i_payload (w_payload),
        .i_ready   (tx_ready),
        .o_data    (tx_data),
        .o_valid   (tx_valid),
        .o_done_c  (w_done)
    );

    // Report sequencer: capture, one compare per cycle, result latch, frame send
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            for (int unsigned i = 0; i < NUM_CAND; i++) begin
                r_vc[i] <= '0;
            end
            r_idx     <= '0;
            r_max     <= '0;
            r_run_win <= '0;
            r_run_tie <= 1'b0;
            r_busy    <= 1'b0;
            r_winner  <= '0;
            r_tie     <= 1'b0;
            r_led     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (report_req && mode) begin
                        r_vc[0]   <= vc1;
                        r_vc[1]   <= vc2;
                        r_vc[2]   <= vc3;
                        r_vc[3]   <= vc4;
                        r_idx     <= '0;
                        r_max     <= '0;
                        r_run_win <= '0;
                        r_run_tie <= 1'b0;
                        r_busy    <= 1'b1;
                        r_led     <= '0;
                        r_state   <= ST_CAPTURE;
                    end else if (!mode) begin
                        r_led <= '0;
                    end
                end
                ST_CAPTURE, ST_COMPARE: begin
                    if (!mode) begin
                        // Leaving result mode mid-compare abandons the report
                        r_busy  <= 1'b0;
                        r_led   <= '0;
                        r_state <= ST_IDLE;
                    end else if (r_idx == 3'(NUM_CAND)) begin
                        r_winner <= r_run_tie ? 3'd0 : r_run_win;
                        r_tie    <= r_run_tie;
                        r_state  <= ST_SEND;
                    end else begin
                        // Strict greater-than takes the lead; an equal count marks a tie
                        if (w_cand > r_max) begin
                            r_max     <= w_cand;
                            r_run_win <= r_idx + 3'd1;
                            r_run_tie <= 1'b0;
                        end else if (w_cand == r_max) begin
                            r_run_tie <= 1'b1;
                        end
                        r_idx   <= r_idx + 3'd1;
                        r_state <= ST_COMPARE;
                    end
                end
                ST_SEND: begin
                    if (w_done) begin
                        r_busy  <= 1'b0;
                        r_led   <= r_tie ? TIE_PATTERN : r_max;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign winner = r_winner;
    assign tie    = r_tie;
    assign led    = r_led;

endmodule

// File: tb/tb_vote_result_reporter.sv
// Directed bench for vote_result_reporter with a byte scoreboard and frame monitor.
module tb_vote_result_reporter;

    logic       clk;
    logic       reset;
    logic       mode;
    logic       report_req;
    logic [7:0] vc1, vc2, vc3, vc4;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic [2:0] winner;
    logic       tie;
    logic [7:0] led;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];

    vote_result_reporter dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .report_req (report_req),
        .vc1        (vc1),
        .vc2        (vc2),
        .vc3        (vc3),
        .vc4        (vc4),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .busy       (busy),
        .winner     (winner),
        .tie        (tie),
        .led        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, input logic [7:0] st, input logic [7:0] cs);
        exp_q.push_back(8'hA5);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
        exp_q.push_back(st);
        exp_q.push_back(cs);
    endtask

    // Full report with hand-computed expectations; optional stall on byte 3 and a stray request
    task automatic run_report(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, input logic [7:0] st, input logic [7:0] cs,
                              input logic [2:0] ew, input logic et, input logic [7:0] eled,
                              input int stall, input bit extra_req);
        push_frame(a, b, c, d, st, cs);
        vc1 = a; vc2 = b; vc3 = c; vc4 = d;
        mode = 1'b1;
        report_req = 1'b1;
        @(posedge clk); #1;
        report_req = 1'b0;
        chk("busy_at_N", busy, 1'b1);
        chk("led_busy", led, 8'h00);
        for (int k = 1; k <= 12 + stall; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                vc1 = 8'hFF; vc2 = 8'hFF; vc3 = 8'hFF; vc4 = 8'hFF;
            end
            if (extra_req && k == 2) report_req = 1'b1;
            if (extra_req && k == 3) report_req = 1'b0;
            if (stall > 0 && k == 7) tx_ready = 1'b0;
            if (stall > 0 && k == 7 + stall) tx_ready = 1'b1;
            if (k == 5) begin
                chk("winner_N5", winner, ew);
                chk("tie_N5", tie, et);
                chk("valid_N5", tx_valid, 1'b1);
                chk("hdr_N5", tx_data, 8'hA5);
            end
            if (k == 11 + stall) chk("busy_last", busy, 1'b1);
            if (k == 12 + stall) begin
                chk("busy_done", busy, 1'b0);
                chk("led_done", led, eled);
                chk("valid_done", tx_valid, 1'b0);
            end
        end
        chk("queue_empty", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("led_hold", led, eled);
        chk("busy_idle", busy, 1'b0);
    endtask

    // Monitor: pops the scoreboard on every transfer and checks hold under backpressure
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [7:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (prev_stall) begin
                    chk("stall_valid", tx_valid, 1'b1);
                    chk("stall_data", tx_data, prev_data);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h expected none at %0t", tx_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_byte", tx_data, e);
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mode = 1'b0; report_req = 1'b0; tx_ready = 1'b1;
        vc1 = '0; vc2 = '0; vc3 = '0; vc4 = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", tx_valid, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_winner", winner, 3'd0);
        chk("rst_tie", tie, 1'b0);
        chk("rst_led", led, 8'h00);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Unique winner
        run_report(8'd3, 8'd9, 8'd2, 8'd7, 8'h02, 8'hA8, 3'd2, 1'b0, 8'h09, 0, 1'b0);

        // Leaving result mode in idle clears LEDs but keeps the result
        mode = 1'b0;
        @(posedge clk); #1;
        chk("led_mode0", led, 8'h00);
        chk("winner_hold", winner, 3'd2);

        // Request in voting mode is ignored
        report_req = 1'b1;
        @(posedge clk); #1;
        report_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("ign_busy", busy, 1'b0);
            chk("ign_valid", tx_valid, 1'b0);
            @(posedge clk); #1;
        end

        // Tie between candidates 2 and 4
        run_report(8'd3, 8'd7, 8'd2, 8'd7, 8'h80, 8'h24, 3'd0, 1'b1, 8'h0F, 0, 1'b0);

        // Backpressure on byte 3
        run_report(8'd3, 8'd9, 8'd2, 8'd7, 8'h02, 8'hA8, 3'd2, 1'b0, 8'h09, 3, 1'b0);

        // Second request while busy
        run_report(8'd3, 8'd9, 8'd2, 8'd7, 8'h02, 8'hA8, 3'd2, 1'b0, 8'h09, 0, 1'b1);

        // All zero counts
        run_report(8'd0, 8'd0, 8'd0, 8'd0, 8'h80, 8'h25, 3'd0, 1'b1, 8'h0F, 0, 1'b0);

        // Early tie cleared by a later strict maximum
        run_report(8'd5, 8'd5, 8'd9, 8'd1, 8'h03, 8'hAE, 3'd3, 1'b0, 8'h09, 0, 1'b0);

        // Mode drop during compare aborts
        vc1 = 8'd3; vc2 = 8'd9; vc3 = 8'd2; vc4 = 8'd7;
        report_req = 1'b1;
        @(posedge clk); #1;
        report_req = 1'b0;
        @(posedge clk); #1;
        mode = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_led", led, 8'h00);
        for (int k = 0; k < 10; k++) begin
            chk("abort_valid", tx_valid, 1'b0);
            @(posedge clk); #1;
        end
        chk("abort_winner", winner, 3'd3);
        chk("abort_tie", tie, 1'b0);

        // Asynchronous reset while byte 4 is on the bus
        mode = 1'b1;
        push_frame(8'd3, 8'd9, 8'd2, 8'd7, 8'h02, 8'hA8);
        report_req = 1'b1;
        @(posedge clk); #1;
        report_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
        end
        #1;
        chk("pre_rst_byte4", tx_data, 8'h02);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_valid", tx_valid, 1'b0);
        chk("mid_rst_data", tx_data, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_winner", winner, 3'd0);
        chk("mid_rst_tie", tie, 1'b0);
        chk("mid_rst_led", led, 8'h00);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", tx_valid, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vote_result_reporter.md
Name: vote_result_reporter

Overview:
- Reads the four 8-bit candidate vote counters when a result report is requested in result mode (mode=1).
- Determines the winner, or a tie, with a sequential compare.
- Streams a 7-byte result frame over a valid/ready byte interface, then drives the LED bus with the winning count.
- Sits downstream of the vote-counting logic as the read-out end of the counter interface.

Parameters:
- FRAME_HEADER, 8'hA5, first byte of every frame.
- TIE_PATTERN, 8'h0F, LED value shown when no unique winner exists.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- mode  input  1  0 = voting mode, 1 = result mode.
- report_req  input  1  single-cycle, already-debounced request pulse.
- vc1  input  8  candidate 1 count.
- vc2  input  8  candidate 2 count.
- vc3  input  8  candidate 3 count.
- vc4  input  8  candidate 4 count.
- tx_ready  input  1  downstream byte sink ready.
- tx_data  output  8  frame byte.
- tx_valid  output  1  tx_data valid.
- busy  output  1  report in progress.
- winner  output  3  0 = none or tie, 1-4 = winning candidate.
- tie  output  1  no unique maximum.
- led  output  8  result display.

Behaviour:
- Reset (asynchronous, reset=0): state IDLE. tx_data=0, tx_valid=0, busy=0, winner=0, tie=0, led=8'h00, all internal snapshots cleared. Reset mid-frame aborts immediately; no partial-frame recovery.
- States: IDLE -> CAPTURE -> COMPARE(x4) -> SEND -> IDLE.
- IDLE:
  - report_req=1 and mode=1 at edge N: snapshot vc1..vc4, busy=1, go to COMPARE.
  - report_req with mode=0 is ignored.
- COMPARE: one candidate per cycle, edges N+1..N+4, in order 1,2,3,4.
  - Running max uses strict greater-than.
  - An equal-to-max count sets the tie flag; a new strict max clears it.
  - All-zero counts give tie=1, winner=0.
- Edge N+5: register winner and tie (winner forced to 0 when tie=1). Enter SEND with tx_valid=1, tx_data=FRAME_HEADER.
- SEND frame order, 7 bytes:
  1. FRAME_HEADER
  2. vc1
  3. vc2
  4. vc3
  5. vc4
  6. status = {tie, 4'b0000, winner}
  7. checksum = XOR of bytes 1-6
- Handshake:
  - A byte transfers on an edge with tx_valid=1 and tx_ready=1; the next byte appears on that same edge.
  - tx_data must hold stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops before its transfer completes.
- Completion: on the edge the checksum transfers:
  - tx_valid=0, busy=0, return to IDLE.
  - led = snapshot count of the winner, or TIE_PATTERN if tie=1.
  - With tx_ready held high, busy is high for edges N..N+11 and low from N+12.
- led:
  - Forced to 8'h00 while busy.
  - Holds the result in IDLE while mode=1.
  - Goes to 8'h00 on the first edge mode=0 is seen in IDLE.
- Simultaneous events:
  - report_req while busy is ignored; no queuing.
  - mode falling during COMPARE aborts to IDLE on that edge (busy=0, led=0).
  - mode falling during SEND is ignored; the frame completes.
- Width rules:
  - Counts are unsigned 8-bit. Counter inputs may change after CAPTURE; only snapshots are used.
  - The checksum is 8-bit XOR with no carry.
- winner and tie hold their values until the next report's edge N+5.

Decomposition:
- Package vote_pkg:
  - state enum (IDLE, CAPTURE, COMPARE, SEND)
  - frame byte index constants (0-6) and FRAME_LEN=7
  - candidate count constant NUM_CAND=4
  - default FRAME_HEADER and TIE_PATTERN
- One natural sub-module, vote_frame_tx: takes a 6-byte payload plus a start pulse, runs the valid/ready byte sequencing, appends the XOR checksum, and pulses done on the last transfer. The comparator and FSM stay in the top.

Test Plan:
- Unique winner: vc={3,9,2,7}, mode=1, report_req, tx_ready=1 -> bytes A5 03 09 02 07 02 A8; winner=2, tie=0; led=09 at N+12; busy low at N+12.
- Tie: vc={3,7,2,7} -> status byte 80, winner=0, tie=1, led=0F; frame A5 03 07 02 07 80, then checksum = XOR of those six bytes.
- Backpressure: same stimulus as the unique-winner case, with tx_ready low for 3 cycles while byte 3 is presented -> tx_data stays 09 with tx_valid=1, no byte skipped or duplicated, completion delayed by exactly 3 cycles.
- Ignored requests:
  - report_req with mode=0 -> busy stays 0, no tx_valid.
  - A second report_req at N+3 -> exactly one frame sent.
- Aborts:
  - mode dropped at N+2 -> busy=0, led=00 at N+2, no tx_valid ever.
  - reset asserted during byte 4 -> all outputs zero immediately (asynchronously, not waiting for an edge); no frame resumes after reset release.
